// File: rtl/lane_regfile_pkg.sv
// Shared types and helpers for the lane-masked register file.
package lane_regfile_pkg;

  typedef enum logic [0:0] {StIdle, StFlush} lrf_state_t;

  // Upper bounds for the generic mask helper; callers truncate to their own width.
  localparam int unsigned LrfMaxLanes = 32;
  localparam int unsigned LrfMaxW     = 256;
  localparam int unsigned LrfLaneIdxW = $clog2(LrfMaxLanes);
  localparam int unsigned LrfBitIdxW  = $clog2(LrfMaxW);

  // Expand a per-lane enable into a per-bit mask for lanes of lw bits.
  function automatic logic [LrfMaxW-1:0] lane_mask(input logic [LrfMaxLanes-1:0] we,
                                                   input int unsigned lw);
    logic [LrfMaxW-1:0] mask;
    int unsigned        li;
    mask = '0;
    for (int unsigned b = 0; b < LrfMaxW; b++) begin
      li = b / lw;
      if (li < LrfMaxLanes) mask[b[LrfBitIdxW-1:0]] = we[li[LrfLaneIdxW-1:0]];
    end
    return mask;
  endfunction

endpackage

// File: rtl/lane_reg.sv
// One register-file entry: LANES lanes of LW bits, per-lane load, synchronous zero,
// asynchronous clear.
module lane_reg #(
  parameter int unsigned LANES = 2,
  parameter int unsigned LW    = 8
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                zero,
  input  logic [LANES-1:0]    we,
  input  logic [LANES*LW-1:0] d,
  output logic [LANES*LW-1:0] q
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LW-1:0] lane_q;

    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        lane_q <= '0;
      end else if (zero) begin
        lane_q <= '0;
      end else if (we[l]) begin
        lane_q <= d[l*LW +: LW];
      end
    end

    assign q[l*LW +: LW] = lane_q;
  end

endmodule

// File: rtl/lane_regfile.sv
// Lane-masked register file with a one-entry-per-cycle flush engine and a registered,
// write-first read port.
module lane_regfile
  import lane_regfile_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned LW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [LANES-1:0]    we,
  input  logic [AW-1:0]       waddr,
  input  logic [LANES*LW-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [LANES*LW-1:0] rdata,
  input  logic                flush_req,
  output logic                busy,
  output logic                flush_done,
  output logic                wr_err
);

  localparam int unsigned W       = LANES * LW;
  localparam logic [AW:0] DepthA  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  lrf_state_t    state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q, flush_done_q, wr_err_q;
  logic [W-1:0]  rdata_q, rdata_d;

  logic [W-1:0]  wmask;
  logic [W-1:0]  stored;
  logic [W-1:0]  entry_q [DEPTH];
  logic          waddr_ok, wr_ok, wr_drop;

  assign wmask    = W'(lane_mask(LrfMaxLanes'(we), LW));
  assign waddr_ok = ({1'b0, waddr} < DepthA);
  assign wr_ok    = (|we) && !busy_q && waddr_ok;
  assign wr_drop  = (|we) && (busy_q || !waddr_ok);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lane_reg #(
      .LANES (LANES),
      .LW    (LW)
    ) u_entry (
      .clk   (clk),
      .clear (clear),
      .zero  (busy_q && (ptr_q == AW'(i))),
      .we    ((wr_ok && (waddr == AW'(i))) ? we : '0),
      .d     (wdata),
      .q     (entry_q[i])
    );
  end

  // Decode by compare so addresses past DEPTH naturally read as zero.
  always_comb begin
    stored = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) stored = entry_q[i];
    end
  end

  always_comb begin
    rdata_d = stored;
    if (wr_ok && (waddr == raddr)) rdata_d = (stored & ~wmask) | (wdata & wmask);
    if (busy_q && (ptr_q == raddr)) rdata_d = '0;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rdata_q      <= rdata_d;
      wr_err_q     <= wr_drop;
      flush_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_req) begin
            state_q <= StFlush;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        StFlush: begin
          if (ptr_q == LastPtr) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
            ptr_q        <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;
  assign wr_err     = wr_err_q;

endmodule
